// File: rtl/batcher_xbar_pkg.sv
// batcher_xbar_pkg: shared defaults, derived pipeline depth and tracker types for the crossbar scheduler
package batcher_xbar_pkg;
   localparam int DEF_SIZE   = 32;
   localparam int DEF_DWIDTH = 16;
   localparam int DEF_NREQ   = 4;
   localparam int DEF_TIDW   = 4;
   localparam int DEF_TAGW   = $clog2(DEF_SIZE);
   localparam int DEF_IDW    = $clog2(DEF_NREQ);
   function automatic int calc_lat(input int tagw);
      return (tagw * (tagw + 1)) / 2;
   endfunction
   localparam int DEF_LAT = calc_lat(DEF_TAGW);
   typedef logic [DEF_SIZE*DEF_DWIDTH-1:0] lane_data_t;
   typedef logic [DEF_SIZE*DEF_TAGW-1:0]   lane_tag_t;
   typedef struct packed {
      logic                valid;
      logic [DEF_IDW-1:0]  id;
      logic [DEF_TIDW-1:0] tid;
   } trk_t;
endpackage

// File: rtl/batcher_xbar_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick over request bits starting at a rotating pointer
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);
   logic w_found;
   function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] p, input int k);
      return IDW'((int'(p) + k) % NREQ);
   endfunction
   // scan from farthest to nearest so the requester closest to the pointer wins
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (i_req[rot(i_ptr, k)]) begin
            o_idx   = rot(i_ptr, k);
            w_found = 1'b1;
         end
      end
      if (i_en && w_found) o_grant[o_idx] = 1'b1;
      o_any = i_en && w_found;
   end
endmodule

// File: rtl/batcher_xbar_sched.sv
// batcher_xbar_sched: shares one pipelined sorting crossbar between requesters and tracks vectors in flight
module batcher_xbar_sched
   import batcher_xbar_pkg::*;
#(
   parameter int SIZE   = DEF_SIZE,
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int NREQ   = DEF_NREQ,
   parameter int TIDW   = DEF_TIDW,
   parameter int TAGW   = $clog2(SIZE),
   parameter int IDW    = $clog2(NREQ),
   parameter int LAT    = calc_lat(TAGW)
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ*SIZE*DWIDTH-1:0] req_data,
   input  logic [NREQ*SIZE*TAGW-1:0]   req_shift,
   input  logic [NREQ*TIDW-1:0]        req_tid,
   output logic                        xbar_en,
   output logic [SIZE*DWIDTH-1:0]      xbar_din,
   output logic [SIZE*TAGW-1:0]        xbar_shift,
   input  logic [SIZE*DWIDTH-1:0]      xbar_dout,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [IDW-1:0]              rsp_id,
   output logic [TIDW-1:0]             rsp_tid,
   output logic [SIZE*DWIDTH-1:0]      rsp_data,
   output logic                        busy,
   output logic [$clog2(LAT+1)-1:0]    inflight
);
   localparam int CW = $clog2(LAT + 1);
   trk_t                   r_trk [LAT];
   logic [IDW-1:0]         r_ptr;
   logic [CW-1:0]          r_cnt;
   logic                   w_adv;
   logic                   w_any;
   logic                   w_ret;
   logic [NREQ-1:0]        w_grant;
   logic [IDW-1:0]         w_idx;
   logic [TIDW-1:0]        w_tid;
   logic [SIZE*TAGW-1:0]   w_ident;
   logic [LAT-1:0]         w_vld;

   // the whole pipeline holds only when a retired vector is refused; reset forces it idle
   assign w_adv = n_rst && !(r_trk[LAT-1].valid && !rsp_ready);
   assign w_ret = r_trk[LAT-1].valid && rsp_ready;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .i_en    (w_adv),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   for (genvar g = 0; g < SIZE; g++) begin : g_ident
      assign w_ident[g*TAGW +: TAGW] = TAGW'(g);
   end
   for (genvar g = 0; g < LAT; g++) begin : g_vld
      assign w_vld[g] = r_trk[g].valid;
   end

   assign w_tid      = req_tid[int'(w_idx)*TIDW +: TIDW];
   assign req_ready  = w_grant;
   assign xbar_en    = w_adv;
   assign xbar_din   = w_any ? req_data[int'(w_idx)*SIZE*DWIDTH +: SIZE*DWIDTH] : '0;
   assign xbar_shift = w_any ? req_shift[int'(w_idx)*SIZE*TAGW +: SIZE*TAGW] : w_ident;
   assign rsp_valid  = r_trk[LAT-1].valid;
   assign rsp_id     = r_trk[LAT-1].id;
   assign rsp_tid    = r_trk[LAT-1].tid;
   assign rsp_data   = xbar_dout;
   assign busy       = |w_vld;
   assign inflight   = r_cnt;

   // tracker shifts in lockstep with the crossbar; head takes the grant or a bubble
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < LAT; i++) r_trk[i] <= '0;
      end else if (w_adv) begin
         r_trk[0] <= {w_any, w_idx, w_tid};
         for (int i = 1; i < LAT; i++) r_trk[i] <= r_trk[i-1];
      end
   end

   // pointer moves just past the winner on every handshake
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_ptr <= '0;
      else if (w_any) r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
   end

   // in-flight count: up on accept, down on retire, unchanged when both happen
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_cnt <= '0;
      else if (w_any && !w_ret) r_cnt <= r_cnt + 1'b1;
      else if (!w_any && w_ret) r_cnt <= r_cnt - 1'b1;
   end
endmodule

// File: tb/tb_batcher_xbar_sched.sv
// tb_batcher_xbar_sched: directed scenarios against a routing crossbar model
module tb_batcher_xbar_sched;
   localparam int SIZE = 32, DWIDTH = 16, NREQ = 4, TIDW = 4, TAGW = 5, IDW = 2, LAT = 15, CW = 4;
   localparam int W = SIZE * DWIDTH, SW = SIZE * TAGW;

   logic                 clk = 1'b0;
   logic                 n_rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W-1:0]    req_data = '0;
   logic [NREQ*SW-1:0]   req_shift = '0;
   logic [NREQ*TIDW-1:0] req_tid = '0;
   logic                 xbar_en;
   logic [W-1:0]         xbar_din, xbar_dout, rsp_data;
   logic [SW-1:0]        xbar_shift;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [IDW-1:0]       rsp_id;
   logic [TIDW-1:0]      rsp_tid;
   logic                 busy;
   logic [CW-1:0]        inflight;
   logic [W-1:0]         xs [LAT];
   int                   chk_cnt = 0, pass_cnt = 0;
   int                   q_id[$], q_tid[$], q_base[$];

   batcher_xbar_sched dut (
      .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_shift(req_shift), .req_tid(req_tid),
      .xbar_en(xbar_en), .xbar_din(xbar_din), .xbar_shift(xbar_shift), .xbar_dout(xbar_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tid(rsp_tid),
      .rsp_data(rsp_data), .busy(busy), .inflight(inflight)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [W-1:0] route(input logic [W-1:0] d, input logic [SW-1:0] s);
      logic [W-1:0] o = '0;
      for (int i = 0; i < SIZE; i++) o[int'(s[i*TAGW +: TAGW])*DWIDTH +: DWIDTH] = d[i*DWIDTH +: DWIDTH];
      return o;
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) for (int i = 0; i < LAT; i++) xs[i] <= '0;
      else if (xbar_en) begin
         xs[0] <= route(xbar_din, xbar_shift);
         for (int i = 1; i < LAT; i++) xs[i] <= xs[i-1];
      end
   end
   assign xbar_dout = xs[LAT-1];

   function automatic logic [W-1:0] din_of(input int base);
      logic [W-1:0] v;
      for (int i = 0; i < SIZE; i++) v[i*DWIDTH +: DWIDTH] = DWIDTH'(base + 2 * (SIZE - 1 - i));
      return v;
   endfunction

   function automatic logic [W-1:0] dout_of(input int base);
      logic [W-1:0] v;
      for (int j = 0; j < SIZE; j++) v[j*DWIDTH +: DWIDTH] = DWIDTH'(base + 2 * j);
      return v;
   endfunction

   task automatic set_req(input int r, input int base, input int tid);
      logic [SW-1:0] s;
      for (int i = 0; i < SIZE; i++) s[i*TAGW +: TAGW] = TAGW'(SIZE - 1 - i);
      req_data[r*W +: W]         = din_of(base);
      req_shift[r*SW +: SW]      = s;
      req_tid[r*TIDW +: TIDW]    = TIDW'(tid);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input int id, input int tid, input int base);
      q_id.push_back(id);
      q_tid.push_back(tid);
      q_base.push_back(base);
   endtask

   task automatic drain(input string nm, input int max_ticks);
      int t = 0;
      int eid, etid, eb;
      while ((q_id.size() != 0 || busy) && t < max_ticks) begin
         if (rsp_valid) begin
            chk_cnt++;
            if (q_id.size() == 0)
               $display("FAIL %s extra response id=%0d tid=%0d, expected none", nm, rsp_id, rsp_tid);
            else begin
               eid = q_id.pop_front(); etid = q_tid.pop_front(); eb = q_base.pop_front();
               if ({rsp_id, rsp_tid, rsp_data} !== {IDW'(eid), TIDW'(etid), dout_of(eb)})
                  $display("FAIL %s id=%0d tid=%0d data=%h, expected id=%0d tid=%0d data=%h",
                           nm, rsp_id, rsp_tid, rsp_data, eid, etid, dout_of(eb));
               else pass_cnt++;
            end
         end
         tick();
         t++;
      end
      chk_cnt++;
      if (q_id.size() != 0) begin
         $display("FAIL %s responses missing=%0d, expected 0", nm, q_id.size());
         q_id.delete(); q_tid.delete(); q_base.delete();
      end else pass_cnt++;
   endtask

   task automatic test_reset;
      for (int r = 0; r < NREQ; r++) set_req(r, 100 * r, r);
      req_valid = '1;
      #1 n_rst = 1'b0;
      #2;
      chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid=%b, expected 0", rsp_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset busy=%b, expected 0", busy); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0) $display("FAIL reset req_ready=%b, expected 0000", req_ready); else pass_cnt++;
      chk_cnt++; if (xbar_en !== 1'b0) $display("FAIL reset xbar_en=%b, expected 0", xbar_en); else pass_cnt++;
      chk_cnt++; if (inflight !== 4'd0) $display("FAIL reset inflight=%0d, expected 0", inflight); else pass_cnt++;
      tick(); tick();
      chk_cnt++; if (req_ready !== 4'b0) $display("FAIL reset_held req_ready=%b, expected 0000", req_ready); else pass_cnt++;
      req_valid = '0;
      n_rst = 1'b1;
      #1;
      chk_cnt++; if (xbar_en !== 1'b1) $display("FAIL reset_release xbar_en=%b, expected 1", xbar_en); else pass_cnt++;
      tick();
   endtask

   task automatic test_round_robin;
      logic [3:0] eg;
      for (int r = 0; r < NREQ; r++) set_req(r, 10 + 100 * r, 2 * r + 1);
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         #1;
         eg = 4'b0001 << (c % 4);
         chk_cnt++;
         if (req_ready !== eg) $display("FAIL rr_grant cycle %0d req_ready=%b, expected %b", c, req_ready, eg);
         else pass_cnt++;
         expect_rsp(c % 4, 2 * (c % 4) + 1, 10 + 100 * (c % 4));
         tick();
      end
      req_valid = '0;
      #1;
      chk_cnt++; if (inflight !== 4'd8) $display("FAIL rr_inflight=%0d, expected 8", inflight); else pass_cnt++;
      drain("rr_rsp", 60);
   endtask

   task automatic test_single;
      int b = int'($urandom_range(0, 30000));
      int lat = 0;
      set_req(0, b, 3);
      req_valid = 4'b0001;
      #1;
      chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_grant req_ready=%b, expected 0001", req_ready); else pass_cnt++;
      do begin
         tick();
         req_valid = '0;
         lat++;
      end while (!rsp_valid && lat < 40);
      chk_cnt++; if (lat !== 15) $display("FAIL single_latency=%0d, expected 15", lat); else pass_cnt++;
      chk_cnt++;
      if ({rsp_id, rsp_tid} !== {2'd0, 4'd3}) $display("FAIL single_tag id=%0d tid=%0d, expected id=0 tid=3", rsp_id, rsp_tid);
      else pass_cnt++;
      chk_cnt++;
      if (rsp_data !== dout_of(b)) $display("FAIL single_data=%h, expected %h", rsp_data, dout_of(b));
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({rsp_valid, busy, inflight} !== 6'b0)
         $display("FAIL single_retire rsp_valid=%b busy=%b inflight=%0d, expected 0 0 0", rsp_valid, busy, inflight);
      else pass_cnt++;
   endtask

   task automatic test_backpressure;
      for (int n = 0; n < 15; n++) begin
         set_req(0, 1000 + 64 * n, n);
         req_valid = 4'b0001;
         expect_rsp(0, n, 1000 + 64 * n);
         tick();
      end
      set_req(0, 1000 + 64 * 15, 15);
      rsp_ready = 1'b0;
      #1;
      chk_cnt++;
      if ({rsp_valid, inflight} !== {1'b1, 4'd15}) $display("FAIL bp_full rsp_valid=%b inflight=%0d, expected 1 15", rsp_valid, inflight);
      else pass_cnt++;
      for (int s = 0; s < 5; s++) begin
         chk_cnt++;
         if ({xbar_en, req_ready} !== 5'b0) $display("FAIL bp_stall cycle %0d xbar_en=%b req_ready=%b, expected 0 0000", s, xbar_en, req_ready);
         else pass_cnt++;
         chk_cnt++;
         if ({rsp_tid, rsp_data} !== {4'd0, dout_of(1000)})
            $display("FAIL bp_hold cycle %0d tid=%0d data=%h, expected tid=0 data=%h", s, rsp_tid, rsp_data, dout_of(1000));
         else pass_cnt++;
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      drain("bp_rsp", 60);
   endtask

   task automatic test_sparse;
      logic ev, eb;
      set_req(2, 3000, 5);
      for (int c = 0; c <= 25; c++) begin
         if (c == 2) set_req(2, 3100, 6);
         if (c == 5) set_req(2, 3200, 7);
         req_valid = (c == 0 || c == 2 || c == 5) ? 4'b0100 : 4'b0000;
         #1;
         ev = (c == 15 || c == 17 || c == 20);
         eb = (c >= 1 && c <= 20);
         chk_cnt++;
         if (rsp_valid !== ev) $display("FAIL sparse_valid cycle %0d rsp_valid=%b, expected %b", c, rsp_valid, ev);
         else pass_cnt++;
         chk_cnt++;
         if (busy !== eb) $display("FAIL sparse_busy cycle %0d busy=%b, expected %b", c, busy, eb);
         else pass_cnt++;
         if (ev) begin
            chk_cnt++;
            if ({rsp_id, rsp_tid, rsp_data} !== {2'd2, TIDW'(c == 15 ? 5 : c == 17 ? 6 : 7), dout_of(c == 15 ? 3000 : c == 17 ? 3100 : 3200)})
               $display("FAIL sparse_rsp cycle %0d id=%0d tid=%0d, expected id=2 tid=%0d", c, rsp_id, rsp_tid, c == 15 ? 5 : c == 17 ? 6 : 7);
            else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_rr_pointer;
      set_req(1, 5000, 9);
      req_valid = 4'b0010;
      expect_rsp(1, 9, 5000);
      tick();
      set_req(1, 5100, 10);
      set_req(3, 5200, 11);
      req_valid = 4'b1010;
      #1;
      chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL ptr_first req_ready=%b, expected 1000", req_ready); else pass_cnt++;
      expect_rsp(3, 11, 5200);
      tick();
      chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL ptr_second req_ready=%b, expected 0010", req_ready); else pass_cnt++;
      expect_rsp(1, 10, 5100);
      tick();
      req_valid = '0;
      drain("ptr_rsp", 40);
   endtask

   task automatic test_reset_midflight;
      int lat = 0;
      for (int n = 0; n < 10; n++) begin
         set_req(0, 6000 + 64 * n, n);
         req_valid = 4'b0001;
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (5) tick();
      chk_cnt++;
      if ({rsp_valid, busy, inflight} !== {2'b11, 4'd10})
         $display("FAIL mid_pre rsp_valid=%b busy=%b inflight=%0d, expected 1 1 10", rsp_valid, busy, inflight);
      else pass_cnt++;
      req_valid = 4'b0001;
      n_rst = 1'b0;
      #1;
      chk_cnt++;
      if ({rsp_valid, busy, inflight} !== 6'b0)
         $display("FAIL mid_reset rsp_valid=%b busy=%b inflight=%0d, expected 0 0 0", rsp_valid, busy, inflight);
      else pass_cnt++;
      chk_cnt++;
      if ({xbar_en, req_ready} !== 5'b0) $display("FAIL mid_reset xbar_en=%b req_ready=%b, expected 0 0000", xbar_en, req_ready);
      else pass_cnt++;
      tick(); tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      n_rst = 1'b1;
      tick();
      set_req(3, 7000, 12);
      req_valid = 4'b1000;
      #1;
      chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL mid_grant req_ready=%b, expected 1000", req_ready); else pass_cnt++;
      do begin
         tick();
         req_valid = '0;
         lat++;
      end while (!rsp_valid && lat < 40);
      chk_cnt++; if (lat !== 15) $display("FAIL mid_latency=%0d, expected 15", lat); else pass_cnt++;
      chk_cnt++;
      if ({rsp_id, rsp_tid, rsp_data} !== {2'd3, 4'd12, dout_of(7000)})
         $display("FAIL mid_rsp id=%0d tid=%0d data=%h, expected id=3 tid=12 data=%h", rsp_id, rsp_tid, rsp_data, dout_of(7000));
      else pass_cnt++;
      tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_idle busy=%b, expected 0", busy); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_sparse();
      test_rr_pointer();
      test_reset_midflight();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/batcher_xbar_sched.md
Name: batcher_xbar_sched

Overview:
Scheduler that shares one pipelined Batcher sorting crossbar (SIZE lanes, LAT registered stages, single global enable) between NREQ requesters.
- Arbitrates round-robin and launches at most one full-width vector per cycle into the crossbar.
- Tracks each in-flight vector's requester id and transaction tag in a shift register kept in lockstep with the crossbar pipeline.
- Presents retired vectors on a valid/ready response port, stalling the whole pipeline under response backpressure.

Parameters:
SIZE, 32, crossbar lane count (power of 2)
DWIDTH, 16, lane data width
NREQ, 4, number of requesters (>=2)
TIDW, 4, transaction tag width
TAGW, $clog2(SIZE), per-lane shift/route tag width (derived)
IDW, $clog2(NREQ), requester id width (derived)
LAT, (TAGW*(TAGW+1))/2, crossbar pipeline depth in enabled cycles (derived; 15 for SIZE=32)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_data  in  NREQ*SIZE*DWIDTH  per-requester lane data
req_shift  in  NREQ*SIZE*TAGW  per-requester lane route tags
req_tid  in  NREQ*TIDW  per-requester transaction tag
xbar_en  out  1  crossbar global advance enable
xbar_din  out  SIZE*DWIDTH  lane data to crossbar
xbar_shift  out  SIZE*TAGW  lane tags to crossbar
xbar_dout  in  SIZE*DWIDTH  crossbar output lanes
rsp_valid  out  1  retired vector valid
rsp_ready  in  1  consumer accept
rsp_id  out  IDW  requester that issued the retired vector
rsp_tid  out  TIDW  transaction tag of the retired vector
rsp_data  out  SIZE*DWIDTH  retired vector (passthrough of xbar_dout)
busy  out  1  any vector in flight
inflight  out  $clog2(LAT+1)  count of valid tracker slots

Behaviour:
- Reset is asynchronous on n_rst low, and clk and n_rst are the only clock and reset.
  - Clears tracker valid bits, sets the round-robin pointer to 0, sets inflight to 0.
  - While n_rst is low: rsp_valid=0, busy=0, req_ready=0, xbar_en=0.
  - The crossbar shares n_rst, so a reset mid-operation discards every in-flight vector silently; no responses are produced for them.
- Tracker: LAT slots, each holding {valid, id, tid}. Slot 0 is the head and slot LAT-1 is the tail.
- advance = !(tail.valid && !rsp_ready). xbar_en = advance.
- When advance is high, the tracker shifts one slot every clock: the head loads the grant (or a bubble with valid=0) and the tail is dropped.
- When advance is low, the tracker and the crossbar both hold.
- Arbitration:
  - Combinational round-robin over req_valid, starting at the pointer.
  - Grant only when advance=1. req_ready[i]=advance && grant[i].
  - On a handshake, the pointer becomes (winner+1) mod NREQ. With no handshake, the pointer is unchanged.
- Crossbar drive: xbar_din/xbar_shift are combinationally muxed from the winner. With no grant, drive 0 data and identity shifts (lane i -> i).
- Latency: a vector accepted at advancing edge k reaches the tail after LAT-1 further advancing edges. From then on rsp_valid=1, rsp_id/rsp_tid come from the tail, and rsp_data=xbar_dout.
- rsp_valid is held, with data stable, until rsp_ready. Stall cycles do not count toward latency.
- Full throughput: one accept and one retire per cycle while rsp_ready=1. There is no internal buffering beyond the crossbar stages.
- Simultaneous retire and accept in the same cycle is legal. A retire with a new head bubble is legal.
- busy=|tracker.valid. inflight is incremented on accept, decremented on retire, and unchanged when both occur.
- req_valid deasserted before ready is permitted (no request-side stability rule).

Decomposition:
- Package batcher_xbar_pkg holds:
  - SIZE/DWIDTH/TAGW/LAT defaults and the derived-LAT function.
  - The tracker entry struct {valid, id, tid}.
  - The lane vector typedefs.
- One sub-module: rr_arbiter (NREQ request bits, pointer, grant-enable; outputs a one-hot grant and the winner index).

Test Plan:
- Single requester 0, one vector with tid=3 and random data, rsp_ready=1: rsp_valid rises exactly 15 cycles after acceptance, rsp_id=0, rsp_tid=3, rsp_data equals the ascending-sorted input.
- All 4 requesters hold valid for 8 cycles: grants follow the order 0,1,2,3,0,1,2,3, responses retire in the same order with matching ids and tids, and inflight peaks at 8.
- Pipeline full with 15 in flight, rsp_ready=0 for 5 cycles: xbar_en=0 and req_ready=0 for those cycles, the tail rsp_data and rsp_tid stay stable, and no vector is lost or duplicated after release.
- Requests on cycles 0, 2 and 5 only, rsp_ready=1: responses appear 15 cycles after each acceptance with bubbles preserved, and busy falls to 0 one cycle after the last retire.
- Requesters 1 and 3 active with pointer at 2: requester 3 wins first, then 1.
- n_rst pulsed low with 10 vectors in flight: rsp_valid, busy and inflight go to 0 immediately, and after release a new request completes with the correct 15-cycle latency.
